// File: rtl/shape_prep_engine.sv
// Per-frame shape pre-processor: walks the shape table, sends dirty slots through the
// multicycle trig/rotate path and writes sin/cos/ix/iy back. Clean slots are skipped.
`ifndef INT_BITS
`define INT_BITS 12
`endif
`ifndef FLOAT_DCM_BITS
`define FLOAT_DCM_BITS 8
`endif
`ifndef FLOAT_BITS
`define FLOAT_BITS 24
`endif

module shape_prep_engine #(
    parameter int MAXSHP    = 16,
    parameter int INTW      = `INT_BITS,
    parameter int DCMW      = `FLOAT_DCM_BITS,
    parameter int FLTW      = `FLOAT_BITS,
    parameter int TRIG_LAT  = 4,
    parameter bit FULL_MODE = 1'b0,
    localparam int ID_W     = $clog2(MAXSHP)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    input  logic                   mark_valid,
    input  logic [ID_W-1:0]        mark_id,
    input  logic                   mark_all,
    output logic [ID_W-1:0]        rd_id,
    input  logic signed [INTW-1:0] rd_angle,
    input  logic [INTW-1:0]        rd_x,
    input  logic [INTW-1:0]        rd_y,
    output logic signed [INTW-1:0] calc_angle,
    output logic signed [FLTW-1:0] calc_x0,
    output logic signed [FLTW-1:0] calc_y0,
    input  logic signed [FLTW-1:0] calc_sin,
    input  logic signed [FLTW-1:0] calc_cos,
    input  logic signed [FLTW-1:0] calc_ix,
    input  logic signed [FLTW-1:0] calc_iy,
    output logic                   wr_en,
    output logic [ID_W-1:0]        wr_id,
    output logic signed [FLTW-1:0] wr_sin,
    output logic signed [FLTW-1:0] wr_cos,
    output logic signed [FLTW-1:0] wr_ix,
    output logic signed [FLTW-1:0] wr_iy,
    output logic [2:0]             dbg_state
);

    localparam int CNT_W = $clog2(TRIG_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SCAN  = 3'd1,
        S_LOAD  = 3'd2,
        S_WAIT  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   cursor;
    logic [CNT_W-1:0]  wait_cnt;
    logic [MAXSHP-1:0] dirty, dirty_nxt;
    logic              slot_dirty, last_slot, wait_over;

    assign slot_dirty = FULL_MODE || dirty[cursor];
    assign last_slot  = (cursor == ID_W'(MAXSHP - 1));
    assign wait_over  = (wait_cnt == CNT_W'(TRIG_LAT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SCAN;
            S_SCAN:  if (slot_dirty)     state_nxt = S_LOAD;
                     else if (last_slot) state_nxt = S_DONE;
            S_LOAD:  state_nxt = S_WAIT;
            S_WAIT:  if (wait_over) state_nxt = S_WRITE;
            S_WRITE: state_nxt = last_slot ? S_DONE : S_SCAN;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs; write data is only driven while the strobe is high
    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        wr_en     = (state == S_WRITE);
        wr_id     = cursor;
        rd_id     = cursor;
        dbg_state = state;
        wr_sin    = '0;
        wr_cos    = '0;
        wr_ix     = '0;
        wr_iy     = '0;
        if (state == S_WRITE) begin
            wr_sin = calc_sin;
            wr_cos = calc_cos;
            wr_ix  = calc_ix;
            wr_iy  = calc_iy;
        end
    end

    // A mark landing on the same cycle as the LOAD clear keeps the slot dirty
    always_comb begin
        dirty_nxt = dirty;
        if (state == S_LOAD) dirty_nxt[cursor] = 1'b0;
        if (mark_all)        dirty_nxt = '1;
        else if (mark_valid) dirty_nxt[mark_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cursor     <= '0;
            wait_cnt   <= '0;
            dirty      <= '1;
            calc_angle <= '0;
            calc_x0    <= '0;
            calc_y0    <= '0;
        end else begin
            dirty <= dirty_nxt;
            case (state)
                S_IDLE:  if (start) cursor <= '0;
                S_SCAN:  if (!slot_dirty && !last_slot) cursor <= cursor + ID_W'(1);
                S_LOAD: begin
                    calc_angle <= rd_angle;
                    calc_x0    <= FLTW'({rd_x, {DCMW{1'b0}}});
                    calc_y0    <= FLTW'({rd_y, {DCMW{1'b0}}});
                    wait_cnt   <= '0;
                end
                S_WAIT:  if (!wait_over) wait_cnt <= wait_cnt + CNT_W'(1);
                S_WRITE: if (!last_slot) cursor <= cursor + ID_W'(1);
                S_DONE:  cursor <= '0;
                default: cursor <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_shape_prep_engine.sv
// Bench for shape_prep_engine: behavioural shape table plus a pipelined trig/rotate model;
// a scoreboard queue holds the expected write-backs of each pass.
module tb_shape_prep_engine;

    localparam int MAXSHP   = 16;
    localparam int INTW     = 12;
    localparam int DCMW     = 8;
    localparam int FLTW     = 24;
    localparam int TRIG_LAT = 4;
    localparam int ID_W     = $clog2(MAXSHP);
    localparam int W        = ID_W + 4 * FLTW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic                   start, busy, done, mark_valid, mark_all;
    logic [ID_W-1:0]        mark_id, rd_id, wr_id;
    logic signed [INTW-1:0] rd_angle, calc_angle;
    logic [INTW-1:0]        rd_x, rd_y;
    logic signed [FLTW-1:0] calc_x0, calc_y0, calc_sin, calc_cos, calc_ix, calc_iy;
    logic                   wr_en;
    logic signed [FLTW-1:0] wr_sin, wr_cos, wr_ix, wr_iy;
    logic [2:0]             dbg_state;

    // second instance in full mode; only its write count is checked
    logic                   f_busy, f_done, f_wr_en;
    logic [ID_W-1:0]        f_rd_id, f_wr_id;
    logic signed [INTW-1:0] f_rd_angle, f_calc_angle;
    logic [INTW-1:0]        f_rd_x, f_rd_y;
    logic signed [FLTW-1:0] f_calc_x0, f_calc_y0;
    logic signed [FLTW-1:0] f_wr_sin, f_wr_cos, f_wr_ix, f_wr_iy;
    logic [2:0]             f_dbg_state;

    logic [INTW-1:0] tbl_angle [MAXSHP];
    logic [INTW-1:0] tbl_x     [MAXSHP];
    logic [INTW-1:0] tbl_y     [MAXSHP];

    assign rd_angle   = tbl_angle[rd_id];
    assign rd_x       = tbl_x[rd_id];
    assign rd_y       = tbl_y[rd_id];
    assign f_rd_angle = tbl_angle[f_rd_id];
    assign f_rd_x     = tbl_x[f_rd_id];
    assign f_rd_y     = tbl_y[f_rd_id];

    shape_prep_engine #(
        .MAXSHP(MAXSHP), .INTW(INTW), .DCMW(DCMW), .FLTW(FLTW),
        .TRIG_LAT(TRIG_LAT), .FULL_MODE(1'b0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .mark_valid(mark_valid), .mark_id(mark_id), .mark_all(mark_all),
        .rd_id(rd_id), .rd_angle(rd_angle), .rd_x(rd_x), .rd_y(rd_y),
        .calc_angle(calc_angle), .calc_x0(calc_x0), .calc_y0(calc_y0),
        .calc_sin(calc_sin), .calc_cos(calc_cos), .calc_ix(calc_ix), .calc_iy(calc_iy),
        .wr_en(wr_en), .wr_id(wr_id), .wr_sin(wr_sin), .wr_cos(wr_cos),
        .wr_ix(wr_ix), .wr_iy(wr_iy), .dbg_state(dbg_state)
    );

    shape_prep_engine #(
        .MAXSHP(MAXSHP), .INTW(INTW), .DCMW(DCMW), .FLTW(FLTW),
        .TRIG_LAT(TRIG_LAT), .FULL_MODE(1'b1)
    ) u_full (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(f_busy), .done(f_done),
        .mark_valid(mark_valid), .mark_id(mark_id), .mark_all(mark_all),
        .rd_id(f_rd_id), .rd_angle(f_rd_angle), .rd_x(f_rd_x), .rd_y(f_rd_y),
        .calc_angle(f_calc_angle), .calc_x0(f_calc_x0), .calc_y0(f_calc_y0),
        .calc_sin('0), .calc_cos('0), .calc_ix('0), .calc_iy('0),
        .wr_en(f_wr_en), .wr_id(f_wr_id), .wr_sin(f_wr_sin), .wr_cos(f_wr_cos),
        .wr_ix(f_wr_ix), .wr_iy(f_wr_iy), .dbg_state(f_dbg_state)
    );

    // ---------------- trig/rotate model ----------------
    function automatic logic signed [FLTW-1:0] sext(input logic [INTW-1:0] a);
        return {{(FLTW-INTW){a[INTW-1]}}, a};
    endfunction
    function automatic logic signed [FLTW-1:0] to_fix(input logic [INTW-1:0] v);
        return {{(FLTW-INTW-DCMW){1'b0}}, v, {DCMW{1'b0}}};
    endfunction
    function automatic logic signed [FLTW-1:0] f_sin(input logic signed [FLTW-1:0] a);
        return FLTW'(a * 5 + 1);
    endfunction
    function automatic logic signed [FLTW-1:0] f_cos(input logic signed [FLTW-1:0] a);
        return ~a;
    endfunction

    // results only become valid TRIG_LAT edges after the inputs change
    logic signed [FLTW-1:0] p_ang [TRIG_LAT];
    logic signed [FLTW-1:0] p_x0  [TRIG_LAT];
    logic signed [FLTW-1:0] p_y0  [TRIG_LAT];
    always @(posedge clk) begin
        p_ang[0] <= sext(calc_angle);
        p_x0[0]  <= calc_x0;
        p_y0[0]  <= calc_y0;
        for (int i = 1; i < TRIG_LAT; i++) begin
            p_ang[i] <= p_ang[i-1];
            p_x0[i]  <= p_x0[i-1];
            p_y0[i]  <= p_y0[i-1];
        end
    end
    assign calc_sin = f_sin(p_ang[TRIG_LAT-1]);
    assign calc_cos = f_cos(p_ang[TRIG_LAT-1]);
    assign calc_ix  = p_x0[TRIG_LAT-1] + p_ang[TRIG_LAT-1];
    assign calc_iy  = p_y0[TRIG_LAT-1] - (p_ang[TRIG_LAT-1] <<< 1);

    // ---------------- scoreboard ----------------
    logic [W-1:0]      exp_q[$];
    logic [MAXSHP-1:0] model_dirty;
    int errors = 0;
    int checks = 0;
    int f_wr_cnt = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_entry(input int i);
        logic signed [FLTW-1:0] a, x0, y0;
        a  = sext(tbl_angle[i]);
        x0 = to_fix(tbl_x[i]);
        y0 = to_fix(tbl_y[i]);
        return {ID_W'(i), f_sin(a), f_cos(a), FLTW'(x0 + a), FLTW'(y0 - (a <<< 1))};
    endfunction

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) check("wr_unexpected", 128'(wr_id), 128'hFFFF);
            else check("wr_data", 128'({wr_id, wr_sin, wr_cos, wr_ix, wr_iy}), 128'(exp_q.pop_front()));
        end
        if (f_wr_en === 1'b1) f_wr_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic randomize_table();
        for (int i = 0; i < MAXSHP; i++) begin
            tbl_angle[i] = INTW'($urandom_range(0, 4095));
            tbl_x[i]     = INTW'($urandom_range(0, 4095));
            tbl_y[i]     = INTW'($urandom_range(0, 4095));
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_busy"},  128'(busy), 128'(0));
        check({pfx, "_done"},  128'(done), 128'(0));
        check({pfx, "_wr_en"}, 128'(wr_en), 128'(0));
        check({pfx, "_rd_id"}, 128'(rd_id), 128'(0));
        check({pfx, "_state"}, 128'(dbg_state), 128'(0));
        check({pfx, "_calc"},  128'({calc_angle, calc_x0, calc_y0}), 128'(0));
    endtask

    task automatic mark_one(input int id, input logic all);
        mark_valid = !all;
        mark_all   = all;
        mark_id    = ID_W'(id);
        @(negedge clk);
        mark_valid = 1'b0;
        mark_all   = 1'b0;
    endtask

    // Entered and left at a negedge. Cycle n is the n-th cycle after the start edge.
    task automatic run_pass(input string name, input int exp_done,
                            input int m1_cyc, input int m1_id, input int m2_cyc, input int m2_id,
                            input int rs_cyc, input int rst_cyc, input int abort_left);
        int cyc;
        int busy_low;
        randomize_table();
        for (int i = 0; i < MAXSHP; i++)
            if (model_dirty[i]) exp_q.push_back(exp_entry(i));
        model_dirty = '0;
        f_wr_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        cyc = 1;
        busy_low = 0;
        while (cyc <= 400) begin
            start = 1'b0;
            mark_valid = 1'b0;
            if (cyc == m1_cyc) begin mark_valid = 1'b1; mark_id = ID_W'(m1_id); end
            if (cyc == m2_cyc) begin mark_valid = 1'b1; mark_id = ID_W'(m2_id); end
            if (cyc == rs_cyc) start = 1'b1;
            if (busy !== 1'b1) busy_low++;
            if (cyc == rst_cyc) begin rst_n = 1'b0; break; end
            if (done === 1'b1) break;
            cyc++;
            @(negedge clk);
        end
        if (rst_cyc > 0) begin
            @(negedge clk);
            check_reset_outputs({name, "_abort"});
            check({name, "_abort_pending"}, 128'(exp_q.size()), 128'(abort_left));
            exp_q.delete();
            model_dirty = '1;
            rst_n = 1'b1;
            @(negedge clk);
        end else begin
            check({name, "_done_cycle"}, 128'(cyc), 128'(exp_done));
            check({name, "_busy_span"}, 128'(busy_low), 128'(0));
            @(negedge clk);
            check({name, "_idle_after"}, 128'({busy, done}), 128'(0));
            check({name, "_all_written"}, 128'(exp_q.size()), 128'(0));
            exp_q.delete();
            for (int k = 0; k < 300 && f_busy === 1'b1; k++) @(negedge clk);
            check({name, "_full_writes"}, 128'(f_wr_cnt), 128'(MAXSHP));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mark_valid = 1'b0;
        mark_all = 1'b0;
        mark_id = '0;
        model_dirty = '1;
        randomize_table();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // all slots dirty; slot 3 re-marked in its own LOAD (cycle 23), slot 2 marked
        // behind the cursor while slot 7 is in flight, start pulsed mid-pass
        run_pass("pass_all", 113, 23, 3, 52, 2, 30, -1, 0);
        model_dirty[3] = 1'b1;
        model_dirty[2] = 1'b1;

        run_pass("pass_remark", 29, -1, 0, -1, 0, -1, -1, 0);
        run_pass("pass_clean", 17, -1, 0, -1, 0, -1, -1, 0);

        mark_one(5, 1'b0);
        model_dirty[5] = 1'b1;
        run_pass("pass_one", 23, -1, 0, -1, 0, -1, -1, 0);
        check("calc_x0_held", 128'(calc_x0), 128'(to_fix(tbl_x[5])));
        check("calc_y0_held", 128'(calc_y0), 128'(to_fix(tbl_y[5])));
        check("calc_ang_held", 128'(calc_angle), 128'(tbl_angle[5]));

        // reset in the WAIT of slot 4 (LOAD at cycle 30)
        mark_one(0, 1'b1);
        model_dirty = '1;
        run_pass("pass_abort", 0, -1, 0, -1, 0, -1, 32, 12);

        run_pass("pass_after_rst", 113, -1, 0, -1, 0, -1, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shape_prep_engine.md
# shape_prep_engine

Per-frame pre-processor for the shape renderers. On each `start` pulse (driven from `sg_endframe`) it walks the shape table and, for every shape marked dirty, fetches angle and position, holds them on a multicycle trig/rotate path, and writes back `sin`, `cos`, `ix`, `iy`. This replaces the fixed-latency, unconditional PREP loop in the controller: the depth, datapath widths and trig latency are parametrised, and clean shapes are skipped via a dirty mask with a start/busy/done handshake.

## Interface
- `MAXSHP`, 16: number of shape slots (≥2).
- `INTW`, `` `INT_BITS ``: integer field width (x, y, angle).
- `DCMW`, `` `FLOAT_DCM_BITS ``: fractional bits of fixed-point values.
- `FLTW`, `` `FLOAT_BITS ``: fixed-point width; `FLTW` ≥ `INTW`+`DCMW`.
- `TRIG_LAT`, 4: cycles the calc inputs are held before results are sampled (≥1).
- `FULL_MODE`, 0: 1 = treat every slot as dirty on every pass.

Ports:
- `clk`  in  1  pixel/system clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  pulse; begins a pass when idle.
- `busy`  out  1  high from the cycle after accepted `start` through the DONE cycle.
- `done`  out  1  one-cycle pulse at the end of a pass.
- `mark_valid`  in  1  set dirty bit `mark_id`.
- `mark_id`  in  $clog2(MAXSHP)  slot to mark.
- `mark_all`  in  1  set all dirty bits.
- `rd_id`  out  $clog2(MAXSHP)  shape-table read index (cursor).
- `rd_angle`  in  INTW signed  angle of `rd_id`, combinational.
- `rd_x`, `rd_y`  in  INTW  position of `rd_id`, combinational.
- `calc_angle`  out  INTW signed  to sin/cos unit.
- `calc_x0`, `calc_y0`  out  FLTW signed  `{rd_x, DCMW'0}`, `{rd_y, DCMW'0}`, zero-extended to FLTW.
- `calc_sin`, `calc_cos`, `calc_ix`, `calc_iy`  in  FLTW signed  trig/rotate results.
- `wr_en`  out  1  write strobe to shape table.
- `wr_id`  out  $clog2(MAXSHP)  slot written (= cursor).
- `wr_sin`, `wr_cos`, `wr_ix`, `wr_iy`  out  FLTW signed  pass-through of `calc_*` during WRITE.

## Operation
- States: IDLE, SCAN, LOAD, WAIT, WRITE, DONE.
- IDLE: `start`=1 → SCAN, cursor=0. Otherwise stay.
- SCAN: dirty[cursor] (or `FULL_MODE`) → LOAD; else cursor==MAXSHP-1 → DONE, else cursor+1, stay in SCAN.
- LOAD: register `calc_angle`/`calc_x0`/`calc_y0` from `rd_*`; clear dirty[cursor]; wait counter=0 → WAIT.
- WAIT: counter+1 each cycle; at counter==TRIG_LAT-1 → WRITE. `calc_*` outputs held stable.
- WRITE: `wr_en`=1 for exactly one cycle, `wr_id`=cursor, `wr_*`=`calc_*`; cursor==MAXSHP-1 → DONE, else cursor+1 → SCAN.
- DONE: `done`=1, cursor=0 → IDLE.
- Dirty mask: set by `mark_valid` or `mark_all` in any state; a set on the same cycle as the LOAD clear of the same slot wins (slot stays dirty for the next pass). A mark on a slot behind the cursor is serviced on the next pass, not the current one.
- `start` outside IDLE is ignored (not queued).
- `busy` = state≠IDLE.

## Timing
- Reset (`rst_n`=0 at a clk edge): state IDLE, cursor/`rd_id`=0, `busy`=`done`=`wr_en`=0, `calc_*`=0, wait counter=0, dirty mask all ones (first pass processes every slot). Reset mid-pass aborts with no further `wr_en`.
- `start` sampled at edge E0 → SCAN in cycle 1.
- Clean slot costs 1 cycle; dirty slot costs TRIG_LAT+3 (SCAN, LOAD, TRIG_LAT×WAIT, WRITE).
- With k dirty slots: `done` high in cycle MAXSHP + k·(TRIG_LAT+2) + 1 after E0; `busy` high cycles 1 through that cycle inclusive.
- `calc_*` change only on LOAD edges; results sampled combinationally in WRITE, i.e. TRIG_LAT+1 cycles after inputs settle.
- `rd_id` valid throughout SCAN and LOAD; `rd_*` must be combinational on `rd_id`.

## Test plan
- Reset, then `start` (MAXSHP=16, TRIG_LAT=4): 16 `wr_en` pulses, ids 0..15 in order, `done` at cycle 16+16·6+1=113; `wr_*` match a model of the trig/rotate path.
- Second `start` with no marks: zero `wr_en`, `done` at cycle 17, `busy` high cycles 1–17.
- `mark_valid`, `mark_id`=5, then `start`: single `wr_en` with `wr_id`=5, `done` at cycle 23; `calc_x0`=`rd_x`<<DCMW.
- `mark_id`=3 asserted in the LOAD cycle of slot 3: slot 3 written this pass and again on the next pass; `mark_id`=2 during slot 7 processing: written only on next pass.
- `start` pulsed while `busy`: no restart, `done` timing unchanged; `FULL_MODE`=1 with no marks: 16 writes every pass.
- `rst_n` low during WAIT of slot 4: `wr_en` never asserted for slot 4; all outputs at reset values next cycle; next `start` writes all 16 slots.
